riscv_mem: RTL and testbench
============================

Name: riscv_mem

Overview:
- Memory-access stage; sits directly downstream of the EX stage and upstream of WB.
- Registers the EX results (pc, instr, bubble, exception, result) into the MEM pipeline register.
- Waits for the data-memory acknowledge of each load or store.
- Aligns and sign/zero-extends load data, and presents mem_r for WB and for the EX bypass path.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- PC_INIT, 'h200, reset value of mem_pc.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- wb_stall  in  1  WB stage is not accepting.
- mem_stall  out  1  MEM is holding; EX must not advance.
- ex_pc  in  XLEN  EX program counter.
- ex_bubble  in  1  EX slot is empty.
- ex_instr  in  ILEN  EX instruction.
- ex_exception  in  EXCEPTION_SIZE  EX exception vector.
- ex_r  in  XLEN  EX result; the effective address for loads and stores.
- dmem_ack  in  1  data-memory transfer complete.
- dmem_q  in  XLEN  raw read data, bus-width aligned.
- st_flush  in  1  state-unit flush.
- du_flush  in  1  debug-unit flush.
- mem_pc  out  XLEN  MEM program counter.
- mem_instr  out  ILEN  MEM instruction.
- mem_bubble  out  1  MEM slot is empty.
- mem_exception  out  EXCEPTION_SIZE  MEM exception vector.
- mem_r  out  XLEN  MEM result, also used as the EX bypass source.

Behaviour:
- Reset values:
  - mem_pc = PC_INIT; mem_instr = INSTR_NOP; mem_bubble = 1.
  - mem_exception = 0; internal result register = 0; state = IDLE.
- Advance: the pipeline register captures EX outputs when !mem_stall. Flush overrides capture.
- Flush (st_flush | du_flush) on a clock edge:
  - mem_bubble <= 1 and mem_exception <= 0.
  - pc, instr and result registers still load as normal.
- Access classification (decided from ex_instr at capture):
  - Memory op = opcode LOAD (7'b0000011) or STORE (7'b0100011).
  - It must also have !ex_bubble and ex_exception == 0.
  - Ops with any exception bit set never wait for dmem_ack.
- FSM states:
  - IDLE: no access pending.
    - Capture of a memory op -> WAIT; any other capture -> IDLE.
  - WAIT: access outstanding; mem_stall = 1.
    - On dmem_ack, a load latches the aligned data into ld_data. State -> DONE.
    - On flush without dmem_ack -> DRAIN.
    - On flush with dmem_ack -> IDLE.
  - DONE: access complete; mem_stall = wb_stall.
    - When advancing: capture of a memory op -> WAIT, otherwise -> IDLE.
  - DRAIN: flushed access still outstanding. mem_stall = 1, mem_bubble = 1, data is discarded.
    - On dmem_ack -> IDLE.
- mem_stall:
  - 1 in WAIT and DRAIN, including the ack cycle.
  - wb_stall in IDLE and DONE.
- Latency:
  - dmem_ack in cycle N -> aligned data on mem_r in cycle N+1.
  - The stage advances at the end of N+1 if !wb_stall.
  - The earliest valid ack is the cycle after capture. An ack in IDLE or DONE is ignored.
- mem_r:
  - DONE with a load: mem_r = ld_data.
  - All other cases: mem_r = the registered ex_r.
- Load alignment. Byte offset = low address bits (2 bits for XLEN=32, 3 bits for XLEN=64). funct3 selects:
  - LB/LBU: 8-bit lane at offset, sign- or zero-extended to XLEN.
  - LH/LHU: 16-bit lane at offset[..:1], sign- or zero-extended.
  - LW/LWU: 32-bit lane; sign-extended, LWU zero-extended (XLEN=64 only).
  - LD: full 64 bits.
  - Misalignment is already flagged in ex_exception and is not re-checked here.
- Simultaneous wb_stall and dmem_ack in WAIT: data is latched, state -> DONE, and MEM holds while wb_stall stays high.
- Reset asserted mid-access returns to IDLE immediately; any late ack is ignored.

Decomposition:
- The shared riscv package supplies ILEN, INSTR_NOP, EXCEPTION_SIZE, the opcode constants (OPC_LOAD, OPC_STORE) and the funct3 load-size constants.
- Add a mem_state_t enum (IDLE, WAIT, DONE, DRAIN) to the package.
- One natural sub-module: riscv_ld_align. It is combinational, taking dmem_q, offset and funct3 and producing the extended XLEN value.

Test Plan:
- ALU op (ex_r=32'h1234) with no wb_stall -> mem_r=32'h1234 next cycle; mem_stall never asserted.
- LB at address 0x103, dmem_q=32'h80xx_xxxx, ack 2 cycles after capture -> mem_stall high for 2 cycles; mem_r=32'hFFFF_FF80 the cycle after ack.
- LHU at address 0x102, dmem_q=32'hBEEF_0000 -> mem_r=32'h0000_BEEF.
- Load in WAIT with st_flush and no ack -> mem_bubble=1 next cycle; stall held through DRAIN until ack; then IDLE; the stale data never reaches mem_r.
- Store whose ex_exception has the misaligned bit set -> no wait; mem_exception carries the bit the next cycle.
- Ack arrives while wb_stall=1 -> DONE; MEM holds mem_r/pc/instr stable until wb_stall falls, then advances one cycle later.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the pipeline stages.
// Holds instruction encodings, exception widths and the MEM-stage state enum.
package riscv_pkg;

  localparam int ILEN           = 32;
  localparam int EXCEPTION_SIZE = 16;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int EXC_LD_MISALIGNED = 4;
  localparam int EXC_ST_MISALIGNED = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/riscv_ld_align.sv
// Load-data aligner: selects the addressed lane of the raw bus word and sign/zero-extends it.
// Purely combinational; no latency, no flow control.
module riscv_ld_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = (XLEN == 64) ? 3 : 2
) (
  input  logic [XLEN-1:0] dmem_q,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] sh;

  // Halfword and word lanes drop the low offset bits, so shifting by the
  // full byte offset lands every lane at bit 0.
  assign sh = dmem_q >> {offset, 3'b000};

  always_comb begin
    q = sh;
    case (funct3)
      F3_LB:   q = XLEN'($signed(sh[7:0]));
      F3_LBU:  q = XLEN'(sh[7:0]);
      F3_LH:   q = XLEN'($signed(sh[15:0]));
      F3_LHU:  q = XLEN'(sh[15:0]);
      F3_LW:   q = XLEN'($signed(sh[31:0]));
      F3_LWU:  q = XLEN'(sh[31:0]);
      default: q = sh;
    endcase
  end

endmodule

// File: rtl/riscv_mem.sv
// MEM stage: registers EX results, waits for each data-memory ack and returns aligned load data.
// Load data appears one cycle after dmem_ack; mem_stall holds EX while an access is outstanding or WB stalls.
module riscv_mem
  import riscv_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wb_stall,
  output logic                      mem_stall,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic                      ex_bubble,
  input  logic [ILEN-1:0]           ex_instr,
  input  logic [EXCEPTION_SIZE-1:0] ex_exception,
  input  logic [XLEN-1:0]           ex_r,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      st_flush,
  input  logic                      du_flush,
  output logic [XLEN-1:0]           mem_pc,
  output logic [ILEN-1:0]           mem_instr,
  output logic                      mem_bubble,
  output logic [EXCEPTION_SIZE-1:0] mem_exception,
  output logic [XLEN-1:0]           mem_r
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  mem_state_t      state, state_nxt;
  logic [XLEN-1:0] r_q, ld_data, ld_aligned;
  logic            bubble_q, flush, ex_mem_op, capture, is_load, ld_latch;

  assign flush     = st_flush | du_flush;
  assign capture   = ~mem_stall;
  assign ex_mem_op = is_mem_op(ex_instr[6:0]) & ~ex_bubble & ~(|ex_exception);
  assign is_load   = (mem_instr[6:0] == OPC_LOAD);

  riscv_ld_align #(.XLEN(XLEN), .OFFW(OFFW)) u_ld_align (
    .dmem_q (dmem_q),
    .offset (r_q[OFFW-1:0]),
    .funct3 (mem_instr[14:12]),
    .q      (ld_aligned)
  );

  // A flush on the capture edge kills the incoming op, so it never waits.
  always_comb begin
    state_nxt = state;
    mem_stall = wb_stall;
    ld_latch  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (capture) state_nxt = (ex_mem_op & ~flush) ? WAIT : IDLE;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          ld_latch  = is_load & ~flush;
          state_nxt = flush ? IDLE : DONE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        mem_stall = 1'b1;
        if (dmem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_pc        <= PC_INIT;
      mem_instr     <= INSTR_NOP;
      bubble_q      <= 1'b1;
      mem_exception <= '0;
      r_q           <= '0;
      ld_data       <= '0;
    end else begin
      if (capture) begin
        mem_pc        <= ex_pc;
        mem_instr     <= ex_instr;
        r_q           <= ex_r;
        bubble_q      <= ex_bubble;
        mem_exception <= ex_exception;
      end
      if (flush) begin
        bubble_q      <= 1'b1;
        mem_exception <= '0;
      end
      if (ld_latch) ld_data <= ld_aligned;
    end
  end

  assign mem_bubble = bubble_q | (state == DRAIN);
  assign mem_r      = (state == DONE && is_load) ? ld_data : r_q;

endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for riscv_mem: a table of single ops plus hand sequences for flush, WB stall and reset.
module tb_riscv_mem;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic                      clk, rstn, wb_stall, mem_stall;
  logic [XLEN-1:0]           ex_pc, ex_r, dmem_q, mem_pc, mem_r;
  logic                      ex_bubble, dmem_ack, st_flush, du_flush, mem_bubble;
  logic [ILEN-1:0]           ex_instr, mem_instr;
  logic [EXCEPTION_SIZE-1:0] ex_exception, mem_exception;

  int checks = 0;
  int errors = 0;

  riscv_mem #(.XLEN(XLEN), .PC_INIT(32'h200)) dut (
    .clk(clk), .rstn(rstn), .wb_stall(wb_stall), .mem_stall(mem_stall),
    .ex_pc(ex_pc), .ex_bubble(ex_bubble), .ex_instr(ex_instr),
    .ex_exception(ex_exception), .ex_r(ex_r), .dmem_ack(dmem_ack),
    .dmem_q(dmem_q), .st_flush(st_flush), .du_flush(du_flush),
    .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_bubble(mem_bubble),
    .mem_exception(mem_exception), .mem_r(mem_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [15:0] exc;
    logic [31:0] q;
    int          ack_at;
    logic [31:0] exp_r;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_bubble = 1'b1; ex_instr = INSTR_NOP; ex_exception = '0; ex_r = '0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] addr, input logic [15:0] exc);
    ex_pc = pc; ex_instr = instr; ex_r = addr; ex_exception = exc; ex_bubble = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    int  stalls;
    bit  left;
    stalls = 0;
    left   = 1'b0;
    wb_stall = 1'b0; dmem_ack = 1'b0; dmem_q = v.q;
    present(pc, v.instr, v.addr, v.exc);
    step();
    idle_ex();
    for (int c = 1; c <= 20; c++) begin
      dmem_ack = (c == v.ack_at);
      @(negedge clk);
      if (!mem_stall) begin
        left = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    dmem_ack = 1'b0;
    check({v.name, " leaves stall"}, 64'(left), 64'd1);
    check({v.name, " stall cycles"}, 64'(stalls), 64'(v.exp_stalls));
    check({v.name, " mem_r"}, 64'(mem_r), 64'(v.exp_r));
    check({v.name, " mem_exception"}, 64'(mem_exception), 64'(v.exc));
    check({v.name, " mem_pc"}, 64'(mem_pc), 64'(pc));
    check({v.name, " mem_bubble"}, 64'(mem_bubble), 64'd0);
    step();
  endtask

  initial begin
    logic [31:0] lw, lb, alu;
    lw  = mk(OPC_LOAD, F3_LW);
    lb  = mk(OPC_LOAD, F3_LB);
    alu = mk(7'b0010011, 3'b000);

    vecs[0] = '{"alu",       alu,                     32'h1234, 16'h0,    32'h0,         0, 32'h0000_1234, 0};
    vecs[1] = '{"lb_103",    lb,                      32'h103,  16'h0,    32'h8012_3456, 2, 32'hFFFF_FF80, 2};
    vecs[2] = '{"lhu_102",   mk(OPC_LOAD, F3_LHU),    32'h102,  16'h0,    32'hBEEF_0000, 1, 32'h0000_BEEF, 1};
    vecs[3] = '{"lh_100",    mk(OPC_LOAD, F3_LH),     32'h100,  16'h0,    32'h1234_8001, 1, 32'hFFFF_8001, 1};
    vecs[4] = '{"lw_200",    lw,                      32'h200,  16'h0,    32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 3};
    vecs[5] = '{"lbu_101",   mk(OPC_LOAD, F3_LBU),    32'h101,  16'h0,    32'h0000_9A00, 1, 32'h0000_009A, 1};
    vecs[6] = '{"lb_100",    lb,                      32'h100,  16'h0,    32'hFFFF_FF7F, 1, 32'h0000_007F, 1};
    vecs[7] = '{"sw_300",    mk(OPC_STORE, F3_LW),    32'h300,  16'h0,    32'hFFFF_FFFF, 2, 32'h0000_0300, 2};
    vecs[8] = '{"sw_misal",  mk(OPC_STORE, F3_LW),    32'h301,  16'h0040, 32'h0,         0, 32'h0000_0301, 0};
    vecs[9] = '{"lw_misal",  lw,                      32'h102,  16'h0010, 32'h0,         0, 32'h0000_0102, 0};

    rstn = 1'b0; wb_stall = 1'b0; dmem_ack = 1'b0; dmem_q = '0;
    st_flush = 1'b0; du_flush = 1'b0; ex_pc = '0;
    idle_ex();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_pc", 64'(mem_pc), 64'h200);
    check("rst mem_instr", 64'(mem_instr), 64'(INSTR_NOP));
    check("rst mem_bubble", 64'(mem_bubble), 64'd1);
    check("rst mem_exception", 64'(mem_exception), 64'd0);
    check("rst mem_r", 64'(mem_r), 64'd0);
    check("rst mem_stall", 64'(mem_stall), 64'd0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 32'h1000 + 32'(i * 4));

    // Flush while waiting: drain the late ack, never expose its data.
    present(32'h2000, lw, 32'h400, '0);
    step();
    idle_ex();
    st_flush = 1'b1;
    @(negedge clk);
    check("flush wait stall", 64'(mem_stall), 64'd1);
    step();
    st_flush = 1'b0;
    @(negedge clk);
    check("drain bubble", 64'(mem_bubble), 64'd1);
    check("drain stall", 64'(mem_stall), 64'd1);
    step();
    dmem_ack = 1'b1; dmem_q = 32'hCAFE_F00D;
    @(negedge clk);
    check("drain ack stall", 64'(mem_stall), 64'd1);
    step();
    dmem_ack = 1'b0;
    present(32'h2004, alu, 32'h55, '0);
    @(negedge clk);
    check("drain done stall", 64'(mem_stall), 64'd0);
    check("drain done bubble", 64'(mem_bubble), 64'd1);
    check("drain stale data", 64'(mem_r), 64'h400);
    step();
    idle_ex();
    @(negedge clk);
    check("post drain mem_r", 64'(mem_r), 64'h55);
    check("post drain bubble", 64'(mem_bubble), 64'd0);
    step();

    // Ack under WB stall: hold everything until wb_stall drops.
    present(32'h3000, lw, 32'h500, '0);
    step();
    idle_ex();
    wb_stall = 1'b1; dmem_ack = 1'b1; dmem_q = 32'h1122_3344;
    @(negedge clk);
    check("wbst ack stall", 64'(mem_stall), 64'd1);
    step();
    dmem_ack = 1'b0; dmem_q = 32'h0;
    present(32'h3004, alu, 32'h77, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("wbst hold stall", 64'(mem_stall), 64'd1);
      check("wbst hold mem_r", 64'(mem_r), 64'h1122_3344);
      check("wbst hold mem_pc", 64'(mem_pc), 64'h3000);
      check("wbst hold mem_instr", 64'(mem_instr), 64'(lw));
      step();
      dmem_ack = 1'b1;
    end
    dmem_ack = 1'b0; wb_stall = 1'b0;
    @(negedge clk);
    check("wbst release stall", 64'(mem_stall), 64'd0);
    check("wbst release mem_r", 64'(mem_r), 64'h1122_3344);
    step();
    idle_ex();
    @(negedge clk);
    check("wbst advance mem_r", 64'(mem_r), 64'h77);
    check("wbst advance mem_pc", 64'(mem_pc), 64'h3004);
    step();

    // Flush together with the ack goes straight back to idle.
    present(32'h4000, lw, 32'h600, '0);
    step();
    idle_ex();
    du_flush = 1'b1; dmem_ack = 1'b1; dmem_q = 32'hAAAA_5555;
    step();
    du_flush = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("dflush ack stall", 64'(mem_stall), 64'd0);
    check("dflush ack bubble", 64'(mem_bubble), 64'd1);
    check("dflush ack mem_r", 64'(mem_r), 64'h600);
    step();

    // Reset in the middle of an access; a later ack must be ignored.
    present(32'h5000, lw, 32'h700, '0);
    step();
    idle_ex();
    #2 rstn = 1'b0;
    #1;
    check("midrst stall", 64'(mem_stall), 64'd0);
    check("midrst bubble", 64'(mem_bubble), 64'd1);
    check("midrst mem_pc", 64'(mem_pc), 64'h200);
    step();
    rstn = 1'b1;
    dmem_ack = 1'b1; dmem_q = 32'h9999_9999;
    @(negedge clk);
    check("late ack stall", 64'(mem_stall), 64'd0);
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late ack mem_r", 64'(mem_r), 64'd0);
    check("late ack bubble", 64'(mem_bubble), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
